// File: rtl/wish_pkg.sv
// Shared state encodings, default widths and round-robin distance helper for the
// Wishbone source arbiter.
package wish_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } wish_state_e;

    localparam int DEF_NUM_SRC    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TGC_WIDTH  = 2;
    localparam int DEF_MAX_OUT    = 4;
    localparam int OUT_W          = 4;

    // Priority distance of idx behind last: last+1 -> 0, last -> n-1.
    function automatic int rr_dist(input int idx, input int last, input int n);
        int d;
        d = idx + n - 1 - last;
        if (d >= n) d = d - n;
        return d;
    endfunction

endpackage

// File: rtl/wish_rr_pick.sv
// Round-robin winner select: first requester after i_last, wrapping; purely
// combinational, zero latency, no backpressure.
module wish_rr_pick
    import wish_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_SRC-1:0] o_win,
    output logic               o_vld
);

    int w_best;

    always_comb begin
        o_win  = '0;
        o_vld  = 1'b0;
        w_best = NUM_SRC;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_req[i] && (rr_dist(i, int'(i_last), NUM_SRC) < w_best)) begin
                w_best   = rr_dist(i, int'(i_last), NUM_SRC);
                o_win    = '0;
                o_win[i] = 1'b1;
                o_vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wish_rr_arb.sv
// Round-robin Wishbone pipelined arbiter: 1-cycle grant latency, combinational m_* path,
// m_stall_i and the outstanding limit stall the owner; non-owners are always stalled.
module wish_rr_arb
    import wish_pkg::*;
#(
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TGC_WIDTH  = DEF_TGC_WIDTH,
    parameter int MAX_OUT    = DEF_MAX_OUT
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_SRC-1:0]            s_cyc_i,
    input  logic [NUM_SRC-1:0]            s_stb_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_dat_i,
    input  logic [NUM_SRC*TGC_WIDTH-1:0]  s_tgc_i,
    output logic [NUM_SRC-1:0]            s_ack_o,
    output logic [NUM_SRC-1:0]            s_stall_o,
    output logic                          m_cyc_o,
    output logic                          m_stb_o,
    output logic [DATA_WIDTH-1:0]         m_dat_o,
    output logic [TGC_WIDTH-1:0]          m_tgc_o,
    input  logic                          m_ack_i,
    input  logic                          m_stall_i,
    output logic [NUM_SRC-1:0]            gnt_o
);

    localparam int               IW      = $clog2(NUM_SRC);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

    wish_state_e           r_state;
    wish_state_e           w_state_nxt;
    logic [NUM_SRC-1:0]    r_gnt;
    logic [IW-1:0]         r_last;
    logic [OUT_W-1:0]      r_out;
    logic [NUM_SRC-1:0]    w_win;
    logic                  w_win_vld;
    logic [IW-1:0]         w_gnt_idx;
    logic [DATA_WIDTH-1:0] w_g_dat;
    logic [TGC_WIDTH-1:0]  w_g_tgc;
    logic                  w_g_cyc;
    logic                  w_g_stb;
    logic                  w_own;
    logic                  w_drain;
    logic                  w_full;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_release;

    wish_rr_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
        .i_req  (s_cyc_i),
        .i_last (r_last),
        .o_win  (w_win),
        .o_vld  (w_win_vld)
    );

    // One-hot AND-OR mux of the granted source.
    always_comb begin
        w_g_dat   = '0;
        w_g_tgc   = '0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_g_dat |= s_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_gnt[i]}};
            w_g_tgc |= s_tgc_i[i*TGC_WIDTH +: TGC_WIDTH] & {TGC_WIDTH{r_gnt[i]}};
            if (r_gnt[i]) w_gnt_idx = IW'(i);
        end
    end

    assign w_g_cyc   = |(s_cyc_i & r_gnt);
    assign w_g_stb   = |(s_stb_i & r_gnt);
    assign w_own     = (r_state == ST_OWN);
    assign w_drain   = (r_state == ST_DRAIN);
    assign w_full    = (r_out == OUT_MAX);
    assign w_inc     = m_stb_o & ~m_stall_i;
    assign w_dec     = m_ack_i & (r_out != '0);
    assign w_release = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_win_vld) w_state_nxt = ST_OWN;
            ST_OWN:   if (!w_g_cyc) w_state_nxt = (r_out == '0) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (r_out == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_cyc_o   = w_own | w_drain;
        m_stb_o   = w_own & w_g_cyc & w_g_stb & ~w_full;
        m_dat_o   = w_own ? w_g_dat : '0;
        m_tgc_o   = w_own ? w_g_tgc : '0;
        s_ack_o   = w_own ? (r_gnt & {NUM_SRC{m_ack_i}}) : '0;
        s_stall_o = w_own ? (~r_gnt | {NUM_SRC{m_stall_i | w_full}}) : '1;
        gnt_o     = r_gnt;
    end

    // Acks beyond the outstanding count are dropped so the counter cannot wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out  <= '0;
            r_gnt  <= '0;
            r_last <= IW'(NUM_SRC - 1);
        end else begin
            if (w_inc && !w_dec)      r_out <= r_out + OUT_W'(1);
            else if (!w_inc && w_dec) r_out <= r_out - OUT_W'(1);

            if ((r_state == ST_IDLE) && w_win_vld) begin
                r_gnt <= w_win;
            end else if (w_release) begin
                r_gnt  <= '0;
                r_last <= w_gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_wish_rr_arb.sv
// Bench for wish_rr_arb: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a transaction-level ownership model.
module tb_wish_rr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int MO = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    s_cyc_i, s_stb_i, s_ack_o, s_stall_o, gnt_o;
    logic [N*DW-1:0] s_dat_i;
    logic [N*TW-1:0] s_tgc_i;
    logic            m_cyc_o, m_stb_o, m_ack_i, m_stall_i;
    logic [DW-1:0]   m_dat_o;
    logic [TW-1:0]   m_tgc_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    wish_rr_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .TGC_WIDTH(TW), .MAX_OUT(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
        .s_ack_o(s_ack_o), .s_stall_o(s_stall_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_dat_o(m_dat_o), .m_tgc_o(m_tgc_o),
        .m_ack_i(m_ack_i), .m_stall_i(m_stall_i), .gnt_o(gnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Model: who owns the bus, whether it is draining, how many strobes await acks.
    int           mdl_owner = -1;
    bit           mdl_drain = 1'b0;
    int           mdl_out   = 0;
    int           mdl_last  = N - 1;
    int           old_out;
    bit           own_m, full_m, acc_m, ackd_m;
    logic [N-1:0] e_gnt, e_ack, e_stall;
    logic         e_stb;
    logic [DW-1:0] e_dat;
    logic [TW-1:0] e_tgc;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("rst_m_cyc", m_cyc_o, 0);
            chk("rst_m_stb", m_stb_o, 0);
            chk("rst_gnt", gnt_o, 0);
            mdl_owner = -1; mdl_drain = 1'b0; mdl_out = 0; mdl_last = N - 1;
        end else begin
            own_m   = (mdl_owner >= 0) && !mdl_drain;
            full_m  = (mdl_out == MO);
            e_gnt   = '0; e_ack = '0; e_stall = '1;
            e_stb   = 1'b0; e_dat = '0; e_tgc = '0;
            if (mdl_owner >= 0) e_gnt[mdl_owner] = 1'b1;
            if (own_m) begin
                e_stb              = s_cyc_i[mdl_owner] && s_stb_i[mdl_owner] && !full_m;
                e_dat              = s_dat_i[mdl_owner*DW +: DW];
                e_tgc              = s_tgc_i[mdl_owner*TW +: TW];
                e_ack[mdl_owner]   = m_ack_i;
                e_stall[mdl_owner] = m_stall_i || full_m;
            end
            chk("m_cyc", m_cyc_o, (mdl_owner >= 0));
            chk("m_stb", m_stb_o, e_stb);
            chk("m_dat", m_dat_o, e_dat);
            chk("m_tgc", m_tgc_o, e_tgc);
            chk("gnt", gnt_o, e_gnt);
            chk("s_ack", s_ack_o, e_ack);
            chk("s_stall", s_stall_o, e_stall);

            acc_m   = e_stb && !m_stall_i;
            ackd_m  = m_ack_i && (mdl_out > 0);
            old_out = mdl_out;
            mdl_out = mdl_out + int'(acc_m) - int'(ackd_m);
            if (mdl_owner < 0) begin
                for (int j = 1; j <= N; j++)
                    if (mdl_owner < 0 && s_cyc_i[(mdl_last + j) % N]) mdl_owner = (mdl_last + j) % N;
                mdl_drain = 1'b0;
            end else if (!mdl_drain) begin
                if (!s_cyc_i[mdl_owner]) begin
                    if (old_out == 0) begin mdl_last = mdl_owner; mdl_owner = -1; end
                    else mdl_drain = 1'b1;
                end
            end else if (old_out == 0) begin
                mdl_last = mdl_owner; mdl_owner = -1; mdl_drain = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    int           ngr, dead, phase, owner_t, acks, xfers, acc;
    logic [N-1:0] g, prev_g;
    int           exp_order[5] = '{0, 1, 2, 3, 0};
    int           got_order[5] = '{-1, -1, -1, -1, -1};

    initial begin
        s_cyc_i = '0; s_stb_i = '0; s_dat_i = '0; s_tgc_i = '0; m_ack_i = 1'b0; m_stall_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("reset_gnt", gnt_o, 0);
        chk("reset_m_cyc", m_cyc_o, 0);
        chk("reset_stall", s_stall_o, 4'hF);
        chk("reset_ack", s_ack_o, 0);
        step;
        rst_ni = 1'b1;

        // Contention: everyone requests, each owner does one transfer then lets go.
        s_cyc_i = 4'hF;
        ngr = 0; dead = 0; phase = 0; owner_t = -1; prev_g = '0;
        for (int c = 0; c < 80 && ngr < 5; c++) begin
            step; #1;
            g = gnt_o;
            if (g != '0 && g != prev_g) begin
                got_order[ngr] = oh2i(g);
                if (ngr > 0) chk("rr_dead_cycles", dead, 1);
                dead = 0; ngr++; phase = 0; owner_t = oh2i(g);
            end else if (g == '0 && ngr > 0) begin
                dead++;
            end
            prev_g = g;
            if (g != '0) begin
                case (phase)
                    0: begin s_stb_i[owner_t] = 1'b1; phase = 1; end
                    1: begin s_stb_i[owner_t] = 1'b0; m_ack_i = 1'b1; phase = 2; end
                    2: begin m_ack_i = 1'b0; s_cyc_i[owner_t] = 1'b0; phase = 3; end
                    default: ;
                endcase
            end else if (owner_t >= 0) begin
                s_cyc_i[owner_t] = 1'b1;
            end
        end
        chk("rr_grant_count", ngr, 5);
        for (int k = 0; k < 5; k++) chk("rr_order", got_order[k], exp_order[k]);
        s_cyc_i = '0; s_stb_i = '0; m_ack_i = 1'b0;
        step; step;

        // Single source 2: three strobes, each acked the following cycle.
        s_cyc_i[2] = 1'b1; s_stb_i[2] = 1'b1;
        #1; chk("single_gnt_before", gnt_o, 0);
        step; #1; chk("single_gnt", gnt_o, 4'b0100);
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            s_stb_i[2] = (k < 3);
            m_ack_i    = (k > 0);
            #1;
            if (s_ack_o[2]) acks++;
            step;
        end
        m_ack_i = 1'b0; s_stb_i = '0; s_cyc_i[2] = 1'b0;
        #1; chk("single_cyc_release", m_cyc_o, 1);
        step; #1;
        chk("single_idle_cyc", m_cyc_o, 0);
        chk("single_idle_gnt", gnt_o, 0);
        chk("single_acks", acks, 3);
        step;

        // Backpressure on source 1.
        s_cyc_i[1] = 1'b1; s_stb_i[1] = 1'b1; s_dat_i[1*DW +: DW] = 32'hA5A5A5A5; m_stall_i = 1'b1;
        step;
        xfers = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (m_stb_o && !m_stall_i) xfers++;
            chk("bp_stall", s_stall_o[1], 1);
            chk("bp_dat", m_dat_o, 32'hA5A5A5A5);
            step;
        end
        m_stall_i = 1'b0;
        #1; if (m_stb_o && !m_stall_i) xfers++;
        step;
        s_stb_i[1] = 1'b0; m_ack_i = 1'b1;
        #1; chk("bp_ack", s_ack_o[1], 1);
        if (m_stb_o && !m_stall_i) xfers++;
        step;
        m_ack_i = 1'b0; s_cyc_i[1] = 1'b0;
        chk("bp_xfers", xfers, 1);
        step; step;

        // Outstanding limit on source 0 with no acks.
        s_cyc_i[0] = 1'b1; s_stb_i[0] = 1'b1;
        step;
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (m_stb_o && !m_stall_i) acc++;
            step;
        end
        chk("lim_accepted", acc, 4);
        #1;
        chk("lim_stb_blocked", m_stb_o, 0);
        chk("lim_stall", s_stall_o[0], 1);
        m_ack_i = 1'b1;
        #1; chk("lim_stall_ack_cycle", s_stall_o[0], 1);
        step;
        m_ack_i = 1'b0;
        #1;
        chk("lim_stb_resume", m_stb_o, 1);
        chk("lim_stall_clear", s_stall_o[0], 0);
        step;
        s_stb_i[0] = 1'b0; m_ack_i = 1'b1;
        repeat (4) step;
        m_ack_i = 1'b0; s_cyc_i[0] = 1'b0;
        step; step;

        // Drain: source 3 releases with two strobes unacknowledged.
        s_cyc_i[3] = 1'b1; s_stb_i[3] = 1'b1;
        step; step; step;
        s_stb_i[3] = 1'b0; s_cyc_i[3] = 1'b0; s_cyc_i[0] = 1'b1;
        #1; chk("drain_own_cyc", m_cyc_o, 1);
        step;
        m_ack_i = 1'b1;
        #1;
        chk("drain_cyc1", m_cyc_o, 1);
        chk("drain_stb", m_stb_o, 0);
        chk("drain_ack1", s_ack_o, 0);
        chk("drain_gnt", gnt_o, 4'b1000);
        step; #1;
        chk("drain_cyc2", m_cyc_o, 1);
        chk("drain_ack2", s_ack_o, 0);
        step;
        m_ack_i = 1'b0;
        #1; chk("drain_cyc3", m_cyc_o, 1);
        step; #1;
        chk("drain_idle_cyc", m_cyc_o, 0);
        chk("drain_idle_gnt", gnt_o, 0);
        step; #1;
        chk("drain_next_gnt", gnt_o, 4'b0001);
        s_cyc_i = '0;
        step; step;

        // Asynchronous reset in the middle of an ownership.
        s_cyc_i[2] = 1'b1; s_stb_i[2] = 1'b1;
        step; step;
        s_stb_i = '0; m_ack_i = 1'b1;
        #1; rst_ni = 1'b0;
        #1;
        chk("arst_m_cyc", m_cyc_o, 0);
        chk("arst_gnt", gnt_o, 0);
        chk("arst_ack", s_ack_o, 0);
        step;
        rst_ni = 1'b1; m_ack_i = 1'b0; s_cyc_i = 4'hF;
        step; #1;
        chk("arst_first_gnt", gnt_o, 4'b0001);
        s_cyc_i = '0;
        step; step;

        // Randomized traffic, one short reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_cyc_i[i]) s_cyc_i[i] = ($urandom_range(3) == 0);
                else if ($urandom_range(7) == 0) s_cyc_i[i] = 1'b0;
                s_dat_i[i*DW +: DW] = $urandom;
            end
            s_stb_i   = N'($urandom);
            s_tgc_i   = (N*TW)'($urandom);
            m_ack_i   = ($urandom_range(19) < 7);
            m_stall_i = ($urandom_range(3) == 0);
            rst_ni    = (c != 1500);
            step;
        end
        rst_ni = 1'b1;
        s_cyc_i = '0; s_stb_i = '0; m_ack_i = 1'b0; m_stall_i = 1'b0;
        repeat (3) step;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
